// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/sub: specials resolve in 2 cycles, cancellation in 5, finite in 6.
// One op in flight; in_ready only in IDLE, result/flags held in DONE until out_ready.
module fpu_addsub_seq #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             overflow,
  output logic             busy
);

  localparam int SIG_W = MANT_BITS + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int EXP_W = EXP_BITS + 2;

  localparam logic [EXP_BITS-1:0]      EXP_ALL1  = '1;
  localparam logic [MANT_BITS-1:0]     MANT_ZERO = '0;
  localparam logic [WIDTH-1:0]         QNAN      = 32'h7FC0_0000;
  localparam logic signed [EXP_W-1:0]  EXP_OVF   = 10'sd255;
  localparam logic signed [EXP_W-1:0]  EXP_UNF   = 10'sd0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_ROUND = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]              r_state;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic                    r_op;
  logic [WIDTH-1:0]        r_result;
  logic                    r_exc;
  logic                    r_ovf;
  logic                    r_sign;
  logic signed [EXP_W-1:0] r_exp;
  logic [EXT_W-1:0]        r_big;
  logic [EXT_W-1:0]        r_small;
  logic [EXT_W:0]          r_sum;
  logic [EXT_W-1:0]        r_mant;

  // Operand classification
  logic [EXP_BITS-1:0]  w_a_exp;
  logic [EXP_BITS-1:0]  w_b_exp;
  logic [MANT_BITS-1:0] w_a_frac;
  logic [MANT_BITS-1:0] w_b_frac;
  logic                 w_eb_sign;
  logic                 w_eff_sub;
  logic                 w_a_nan;
  logic                 w_b_nan;
  logic                 w_a_inf;
  logic                 w_b_inf;
  logic                 w_a_zero;
  logic                 w_b_zero;

  assign w_a_exp   = r_a[WIDTH-2 -: EXP_BITS];
  assign w_b_exp   = r_b[WIDTH-2 -: EXP_BITS];
  assign w_a_frac  = r_a[MANT_BITS-1:0];
  assign w_b_frac  = r_b[MANT_BITS-1:0];
  assign w_eb_sign = r_b[WIDTH-1] ^ r_op;
  assign w_eff_sub = r_a[WIDTH-1] ^ w_eb_sign;
  assign w_a_nan   = (w_a_exp == EXP_ALL1) && (w_a_frac != MANT_ZERO);
  assign w_b_nan   = (w_b_exp == EXP_ALL1) && (w_b_frac != MANT_ZERO);
  assign w_a_inf   = (w_a_exp == EXP_ALL1) && (w_a_frac == MANT_ZERO);
  assign w_b_inf   = (w_b_exp == EXP_ALL1) && (w_b_frac == MANT_ZERO);
  assign w_a_zero  = (w_a_exp == '0);
  assign w_b_zero  = (w_b_exp == '0);

  // Alignment: magnitude ordering compares exponent then fraction in one go
  logic                 w_a_ge_b;
  logic                 w_big_sign;
  logic [EXT_W-1:0]     w_sig_a;
  logic [EXT_W-1:0]     w_sig_b;
  logic [EXT_W-1:0]     w_big_sig;
  logic [EXT_W-1:0]     w_small_sig;
  logic [EXT_W-1:0]     w_shifted;
  logic [EXT_W-1:0]     w_lost;
  logic [EXT_W-1:0]     w_aligned;
  logic [EXP_BITS-1:0]  w_big_exp;
  logic [EXP_BITS-1:0]  w_small_exp;
  logic [EXP_BITS-1:0]  w_exp_diff;

  assign w_a_ge_b    = r_a[WIDTH-2:0] >= r_b[WIDTH-2:0];
  assign w_sig_a     = {1'b1, w_a_frac, 3'b000};
  assign w_sig_b     = {1'b1, w_b_frac, 3'b000};
  assign w_big_sig   = w_a_ge_b ? w_sig_a : w_sig_b;
  assign w_small_sig = w_a_ge_b ? w_sig_b : w_sig_a;
  assign w_big_exp   = w_a_ge_b ? w_a_exp : w_b_exp;
  assign w_small_exp = w_a_ge_b ? w_b_exp : w_a_exp;
  assign w_big_sign  = w_a_ge_b ? r_a[WIDTH-1] : w_eb_sign;
  assign w_exp_diff  = w_big_exp - w_small_exp;

  always_comb begin
    w_shifted = w_small_sig >> w_exp_diff;
    w_lost    = w_small_sig & ((EXT_W'(1) << w_exp_diff) - EXT_W'(1));
    if (w_exp_diff >= EXP_BITS'(EXT_W)) begin
      w_aligned = EXT_W'(1);
    end else begin
      w_aligned = {w_shifted[EXT_W-1:1], w_shifted[0] | (|w_lost)};
    end
  end

  // Leading-zero count over the non-carry sum bits; last hit is the highest set bit
  logic [4:0]       w_lz;
  logic [EXT_W-1:0] w_norm;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (r_sum[i]) w_lz = 5'(EXT_W - 1 - i);
    end
  end

  assign w_norm = r_sum[EXT_W-1:0] << w_lz;

  // Round to nearest even on G/R/S, carry out of the significand bumps the exponent
  logic                    w_round_up;
  logic [SIG_W:0]          w_rsig;
  logic signed [EXP_W-1:0] w_rexp;
  logic [MANT_BITS-1:0]    w_rfrac;

  assign w_round_up = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_rsig     = {1'b0, r_mant[EXT_W-1:3]} + (SIG_W+1)'(w_round_up);
  assign w_rexp     = w_rsig[SIG_W] ? r_exp + EXP_W'(1) : r_exp;
  assign w_rfrac    = w_rsig[SIG_W] ? w_rsig[SIG_W-1:1] : w_rsig[MANT_BITS-1:0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_big    <= '0;
      r_small  <= '0;
      r_sum    <= '0;
      r_mant   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= operation_select;
            r_exc   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_state <= S_DONE;
          if (w_a_nan || w_b_nan) begin
            r_result <= QNAN;
            r_exc    <= 1'b1;
          end else if (w_a_inf && w_b_inf) begin
            if (r_a[WIDTH-1] == w_eb_sign) begin
              r_result <= {r_a[WIDTH-1], EXP_ALL1, MANT_ZERO};
            end else begin
              r_result <= QNAN;
              r_exc    <= 1'b1;
            end
          end else if (w_a_inf) begin
            r_result <= r_a;
          end else if (w_b_inf) begin
            r_result <= {w_eb_sign, EXP_ALL1, MANT_ZERO};
          end else if (w_a_zero && w_b_zero) begin
            r_result <= {r_a[WIDTH-1] & w_eb_sign, {(WIDTH-1){1'b0}}};
          end else if (w_a_zero) begin
            r_result <= {w_eb_sign, r_b[WIDTH-2:0]};
          end else if (w_b_zero) begin
            r_result <= r_a;
          end else begin
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign  <= w_big_sign;
          r_exp   <= EXP_W'(w_big_exp);
          r_big   <= w_big_sig;
          r_small <= w_aligned;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= w_eff_sub ? {1'b0, r_big} - {1'b0, r_small}
                               : {1'b0, r_big} + {1'b0, r_small};
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum[EXT_W]) begin
            r_mant  <= {r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
            r_exp   <= r_exp + EXP_W'(1);
            r_state <= S_ROUND;
          end else if (r_sum == '0) begin
            r_result <= '0;
            r_state  <= S_DONE;
          end else begin
            r_mant  <= w_norm;
            r_exp   <= r_exp - EXP_W'(w_lz);
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= S_DONE;
          if (w_rexp >= EXP_OVF) begin
            r_result <= {r_sign, EXP_ALL1, MANT_ZERO};
            r_ovf    <= 1'b1;
          end else if (w_rexp <= EXP_UNF) begin
            r_result <= {r_sign, {(WIDTH-1){1'b0}}};
          end else begin
            r_result <= {r_sign, w_rexp[EXP_BITS-1:0], w_rfrac};
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign exception = r_exc;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Randomized bench for fpu_addsub_seq against a real-arithmetic reference model.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        operation_select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        exception;
  logic        overflow;
  logic        busy;

  int checks;
  int failures;

  always #5 clk = ~clk;

  fpu_addsub_seq #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a                (a),
    .b                (b),
    .operation_select (operation_select),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .exception        (exception),
    .overflow         (overflow),
    .busy             (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact-enough sum in double precision, then rounded once to 24 bits with unbounded exponent.
  task automatic ref_model(input logic [31:0] ma, input logic [31:0] mb, input logic mop,
                           output logic [31:0] r, output logic exc, output logic ovf,
                           output int lat);
    logic sa, sb;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    real da, db, ds;
    logic [63:0] bits;
    logic [24:0] keep;
    logic g, st;
    int e;
    sa = ma[31]; ea = ma[30:23]; fa = ma[22:0];
    sb = mb[31] ^ mop; eb = mb[30:23]; fb = mb[22:0];
    nan_a = (ea == 8'hFF) && (fa != 0);
    nan_b = (eb == 8'hFF) && (fb != 0);
    inf_a = (ea == 8'hFF) && (fa == 0);
    inf_b = (eb == 8'hFF) && (fb == 0);
    z_a = (ea == 0);
    z_b = (eb == 0);
    r = 32'h0; exc = 1'b0; ovf = 1'b0; lat = 2;
    if (nan_a || nan_b) begin
      r = 32'h7FC00000; exc = 1'b1;
    end else if (inf_a && inf_b) begin
      if (sa == sb) r = {sa, 8'hFF, 23'd0};
      else begin r = 32'h7FC00000; exc = 1'b1; end
    end else if (inf_a) begin
      r = ma;
    end else if (inf_b) begin
      r = {sb, 8'hFF, 23'd0};
    end else if (z_a && z_b) begin
      r = {sa & sb, 31'd0};
    end else if (z_a) begin
      r = {sb, mb[30:0]};
    end else if (z_b) begin
      r = ma;
    end else begin
      da = $bitstoreal({sa, 11'(ea) + 11'd896, fa, 29'd0});
      db = $bitstoreal({sb, 11'(eb) + 11'd896, fb, 29'd0});
      ds = da + db;
      if (ds == 0.0) begin
        r = 32'h0; lat = 5;
      end else begin
        lat = 6;
        bits = $realtobits(ds);
        e = int'(bits[62:52]) - 1023 + 127;
        keep = {2'b01, bits[51:29]};
        g = bits[28];
        st = |bits[27:0];
        if (g && (st || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin e++; keep = keep >> 1; end
        if (e >= 255) begin r = {bits[63], 8'hFF, 23'd0}; ovf = 1'b1; end
        else if (e <= 0) r = {bits[63], 31'd0};
        else r = {bits[63], 8'(e), keep[22:0]};
      end
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top, input int hold);
    logic [31:0] er;
    logic ee, eo;
    int elat, cyc;
    ref_model(ta, tb_v, top, er, ee, eo, elat);
    @(negedge clk);
    a = ta; b = tb_v; operation_select = top; in_valid = 1'b1; out_ready = 1'b0;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; operation_select = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(elat));
    if (!out_valid) return;
    check_eq("result", result, er);
    check_eq("exception", 32'(exception), 32'(ee));
    check_eq("overflow", 32'(overflow), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_result", result, er);
      check_eq("hold_flags", {30'd0, exception, overflow}, {30'd0, ee, eo});
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: v = {v[31], 31'd0};
      1: v = {v[31], 8'hFF, 23'd0};
      2: v = {v[31], 8'hFF, v[22:0] | 23'd1};
      3: v = {v[31], 8'h00, v[22:0]};
      4: v = {v[31], 8'(250 + $urandom_range(0, 4)), v[22:0]};
      default: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
    endcase
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_result"}, result, 32'd0);
    check_eq({tag, "_exception"}, 32'(exception), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int e, sel, hold;
    checks = 0; failures = 0;
    arst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; operation_select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    arst_n = 1'b1;

    run_op(32'h3F800000, 32'h40000000, 1'b0, 0);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 0);
    run_op(32'h80000000, 32'h80000000, 1'b0, 0);
    run_op(32'h7FC00001, 32'h3F800000, 1'b0, 0);
    run_op(32'h7F800000, 32'h7F800000, 1'b1, 0);
    run_op(32'h3F800000, 32'h7F800000, 1'b1, 0);
    run_op(32'h3F800000, 32'h33800000, 1'b0, 0);
    run_op(32'h3F800000, 32'h33800001, 1'b0, 0);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0);
    run_op(32'h3F800000, 32'h40000000, 1'b0, 10);
    run_op(32'hC0490FDB, 32'h3F800000, 1'b1, 0);

    // Reset while in ALIGN: outputs must drop to reset values immediately
    @(negedge clk);
    a = 32'h40400000; b = 32'h3F800000; operation_select = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("midop_busy", 32'(busy), 32'd1);
    arst_n = 1'b0;
    #1;
    check_reset_outputs("midop");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("midop_no_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    arst_n = 1'b1;
    run_op(32'h40400000, 32'h3F800000, 1'b0, 0);

    for (int n = 0; n < 400; n++) begin
      ra = rand_operand();
      sel = $urandom_range(0, 3);
      case (sel)
        1: begin
          e = int'(ra[30:23]) + int'($urandom_range(0, 60)) - 30;
          if (e < 1) e = 1;
          if (e > 254) e = 254;
          rb = $urandom;
          rb[30:23] = 8'(e);
        end
        2: begin
          rb = ra;
          rb[2:0] = rb[2:0] ^ 3'($urandom_range(0, 7));
          rb[31] = 1'($urandom_range(0, 1));
        end
        default: rb = rand_operand();
      endcase
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(ra, rb, 1'($urandom_range(0, 1)), hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
